// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text-line renderer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SEND,
        ST_ADV,
        ST_SPACE,
        ST_DONE
    } lcd_state_e;

    localparam int unsigned LCD_COLS      = 14;
    localparam int unsigned LCD_ROW_BYTES = 84;

    // font_enable bit positions
    localparam int unsigned FE_ADV  = 0;
    localparam int unsigned FE_LINE = 1;
    localparam int unsigned FE_CLR  = 2;

    localparam logic [7:0] LCD_SPACE_CODE = 8'h20;

endpackage

// File: rtl/lcd_text_buffer.sv
// Character buffer: one synchronous write port, one combinational read port,
// reset fills every entry with the space code.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= LCD_SPACE_CODE;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Walks the text buffer, fetches glyph columns from the font store and
// streams them (plus spacer columns) to the LCD writer over valid/ready.
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned COLS     = LCD_COLS,
    parameter int unsigned SPACER   = 1,
    parameter int unsigned FONT_LAT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        text_we,
    input  logic [3:0]  text_waddr,
    input  logic [7:0]  text_wdata,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [14:0] font_address,
    output logic [2:0]  font_enable,
    input  logic [4:0]  font_symbolwidth,
    input  logic [7:0]  font_data,
    output logic [7:0]  px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        px_last
);

    localparam int unsigned CI_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned WC_W = (FONT_LAT > 1) ? $clog2(FONT_LAT) : 1;
    localparam int unsigned SC_W = (SPACER > 1) ? $clog2(SPACER) : 1;

    localparam logic [CI_W-1:0] CI_LAST    = CI_W'(COLS - 1);
    localparam logic [WC_W-1:0] WC_LAST    = WC_W'(FONT_LAT - 1);
    localparam logic [SC_W-1:0] SC_LAST    = SC_W'((SPACER > 0) ? SPACER - 1 : 0);
    localparam bit              HAS_SPACER = (SPACER > 0);

    lcd_state_e      state_q, state_d;
    logic [CI_W-1:0] ci_q, ci_d;
    logic [4:0]      col_q, col_d;
    logic [4:0]      w_q, w_d;
    logic [WC_W-1:0] wc_q, wc_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      fe_q, fe_d;
    logic [14:0]     addr_q, addr_d;
    logic [7:0]      px_data_q, px_data_d;
    logic            px_valid_q, px_valid_d;
    logic            px_last_q, px_last_d;

    logic            buf_we;
    logic [3:0]      rd_addr;
    logic [7:0]      rd_data;
    logic            last_char;
    logic            finish_glyph;
    logic            next_char;

    assign buf_we = text_we && ({1'b0, text_waddr} < 5'(COLS));

    // The read port always points at the character that the next CLEAR will load.
    always_comb begin
        if (state_q == ST_IDLE || state_q == ST_DONE) begin
            rd_addr = 4'd0;
        end else begin
            rd_addr = 4'(ci_q) + 4'd1;
        end
    end

    lcd_text_buffer #(
        .DEPTH (16),
        .AW    (4)
    ) u_text_buffer (
        .clock (clock),
        .reset (reset),
        .we    (buf_we),
        .waddr (text_waddr),
        .wdata (text_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign last_char = (ci_q == CI_LAST);

    always_comb begin
        state_d      = state_q;
        ci_d         = ci_q;
        col_d        = col_q;
        w_d          = w_q;
        wc_d         = wc_q;
        sc_d         = sc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fe_d         = '0;
        addr_d       = addr_q;
        px_data_d    = px_data_q;
        px_valid_d   = px_valid_q;
        px_last_d    = px_last_q;
        finish_glyph = 1'b0;
        next_char    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_CLEAR;
                    busy_d       = 1'b1;
                    ci_d         = '0;
                    col_d        = '0;
                    fe_d[FE_CLR] = 1'b1;
                    addr_d       = {7'b0, rd_data};
                end
            end
            ST_CLEAR, ST_ADV: begin
                state_d = ST_LOAD;
                wc_d    = '0;
            end
            ST_LOAD: begin
                if (wc_q == WC_LAST) begin
                    w_d = font_symbolwidth;
                    if (font_symbolwidth == 5'd0) begin
                        finish_glyph = 1'b1;
                    end else begin
                        state_d    = ST_SEND;
                        px_valid_d = 1'b1;
                        px_data_d  = font_data;
                        px_last_d  = !HAS_SPACER && last_char &&
                                     (col_q + 5'd1 >= font_symbolwidth);
                    end
                end else begin
                    wc_d = wc_q + WC_W'(1);
                end
            end
            ST_SEND: begin
                if (px_ready) begin
                    if (col_q + 5'd1 < w_q) begin
                        state_d      = ST_ADV;
                        col_d        = col_q + 5'd1;
                        fe_d[FE_ADV] = 1'b1;
                        px_valid_d   = 1'b0;
                        px_last_d    = 1'b0;
                    end else begin
                        finish_glyph = 1'b1;
                    end
                end
            end
            ST_SPACE: begin
                if (px_ready) begin
                    if (sc_q != SC_LAST) begin
                        sc_d      = sc_q + SC_W'(1);
                        px_last_d = last_char && (sc_q + SC_W'(1) == SC_LAST);
                    end else begin
                        next_char = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Zero-width glyphs and finished glyphs share the spacer/next-char path.
        if (finish_glyph) begin
            if (HAS_SPACER) begin
                state_d    = ST_SPACE;
                sc_d       = '0;
                px_valid_d = 1'b1;
                px_data_d  = '0;
                px_last_d  = last_char && (SC_LAST == '0);
            end else begin
                next_char = 1'b1;
            end
        end

        if (next_char) begin
            px_valid_d = 1'b0;
            px_last_d  = 1'b0;
            if (last_char) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                state_d      = ST_CLEAR;
                ci_d         = ci_q + CI_W'(1);
                col_d        = '0;
                fe_d[FE_CLR] = 1'b1;
                addr_d       = {7'b0, rd_data};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ci_q       <= '0;
            col_q      <= '0;
            w_q        <= '0;
            wc_q       <= '0;
            sc_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fe_q       <= '0;
            addr_q     <= '0;
            px_data_q  <= '0;
            px_valid_q <= 1'b0;
            px_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ci_q       <= ci_d;
            col_q      <= col_d;
            w_q        <= w_d;
            wc_q       <= wc_d;
            sc_q       <= sc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fe_q       <= fe_d;
            addr_q     <= addr_d;
            px_data_q  <= px_data_d;
            px_valid_q <= px_valid_d;
            px_last_q  <= px_last_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign font_enable  = fe_q;
    assign font_address = addr_q;
    assign px_data      = px_data_q;
    assign px_valid     = px_valid_q;
    assign px_last      = px_last_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Scoreboard bench for lcd_text_sequencer with a pipelined font-store model.
module tb_lcd_text_sequencer;
    import lcd_pkg::*;

    localparam int unsigned COLS     = 14;
    localparam int unsigned SPACER   = 1;
    localparam int unsigned FONT_LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        text_we = 1'b0;
    logic [3:0]  text_waddr = '0;
    logic [7:0]  text_wdata = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [14:0] font_address;
    logic [2:0]  font_enable;
    logic [4:0]  font_symbolwidth;
    logic [7:0]  font_data;
    logic [7:0]  px_data;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic        px_last;

    always #5 clock = ~clock;

    lcd_text_sequencer #(
        .COLS     (COLS),
        .SPACER   (SPACER),
        .FONT_LAT (FONT_LAT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .text_we          (text_we),
        .text_waddr       (text_waddr),
        .text_wdata       (text_wdata),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .font_address     (font_address),
        .font_enable      (font_enable),
        .font_symbolwidth (font_symbolwidth),
        .font_data        (font_data),
        .px_data          (px_data),
        .px_valid         (px_valid),
        .px_ready         (px_ready),
        .px_last          (px_last)
    );

    // ---------------- font store model ----------------
    bit         blank_zero = 1'b0;
    logic [4:0] fcol = '0;
    logic [4:0] fnext;
    logic [7:0] fpipe [FONT_LAT];

    function automatic logic [7:0] glyph(input logic [7:0] code, input logic [4:0] c);
        return 8'(code * 8'd3 + {3'b0, c} * 8'd29 + 8'd1);
    endfunction

    function automatic logic [4:0] gwidth(input logic [7:0] code);
        return (blank_zero && code == 8'h20) ? 5'd0 : 5'd5;
    endfunction

    assign font_symbolwidth = gwidth(font_address[7:0]);
    assign fnext = font_enable[FE_CLR] ? 5'd0 :
                   font_enable[FE_ADV] ? fcol + 5'd1 : fcol;
    assign font_data = fpipe[FONT_LAT-1];

    always @(posedge clock) begin
        fcol     <= fnext;
        fpipe[0] <= glyph(font_address[7:0], fnext);
        for (int k = 1; k < FONT_LAT; k++) fpipe[k] <= fpipe[k-1];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [8:0] exp_q [$];
    logic [7:0] text_m [16];
    int         byte_cnt = 0;
    int         clr_cnt  = 0;
    int         exp_total;
    int         exp_cyc;
    int         line_cyc;
    bit         expect_done = 1'b0;
    bit         rdy_rand = 1'b0;
    bit         prev_hold = 1'b0;
    logic [8:0] prev_val;
    logic [8:0] mon_e;

    // Monitor: sampled on the falling edge, i.e. before the next handshake edge.
    always @(negedge clock) begin
        if (reset) begin
            prev_hold   = 1'b0;
            expect_done = 1'b0;
        end else begin
            check_eq("done_pulse", done, expect_done);
            expect_done = 1'b0;
            if (prev_hold) begin
                check_eq("hold_valid", px_valid, 1);
                check_eq("hold_data", {px_last, px_data}, prev_val);
            end
            if (font_enable[FE_CLR]) clr_cnt++;
            if (px_valid && px_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_size", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("px_byte", {px_last, px_data}, mon_e);
                end
                byte_cnt++;
                if (px_last) expect_done = 1'b1;
            end
            prev_hold = px_valid && !px_ready;
            prev_val  = {px_last, px_data};
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #2;
            px_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus tasks ----------------
    task automatic write_char(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        text_we    = 1'b1;
        text_waddr = a;
        text_wdata = d;
        @(negedge clock);
        text_we = 1'b0;
        if (int'(a) < COLS) text_m[a] = d;
    endtask

    task automatic start_line();
        logic [7:0] code;
        logic [4:0] w;
        int         lat;
        exp_q.delete();
        exp_total = 0;
        exp_cyc   = 1;
        for (int ci = 0; ci < COLS; ci++) begin
            code = text_m[ci];
            w    = gwidth(code);
            for (int c = 0; c < int'(w); c++) exp_q.push_back({1'b0, glyph(code, 5'(c))});
            for (int s = 0; s < SPACER; s++)
                exp_q.push_back({(ci == COLS - 1 && s == SPACER - 1), 8'h00});
            exp_total += int'(w) + SPACER;
            exp_cyc   += (w == 0) ? (1 + FONT_LAT + SPACER) : (int'(w) * (2 + FONT_LAT) + SPACER);
        end
        @(negedge clock);
        byte_cnt = 0;
        clr_cnt  = 0;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        line_cyc = 1;
        check_eq("busy_on_start", busy, 1);
        check_eq("clear_first", font_enable, 3'b100);
        check_eq("addr_first", font_address, {7'b0, text_m[0]});
        lat = 0;
        while (!px_valid && lat < 50) begin
            @(negedge clock);
            lat++;
            line_cyc++;
        end
        check_eq("first_valid_lat", lat, FONT_LAT + 1);
    endtask

    task automatic finish_line(input bit timing, input bit start_on_done);
        int budget;
        budget = 0;
        while (!done && budget < 6000) begin
            @(negedge clock);
            line_cyc++;
            budget++;
        end
        check_eq("done_seen", done, 1);
        if (timing) check_eq("line_cycles", line_cyc, exp_cyc);
        check_eq("byte_count", byte_cnt, exp_total);
        check_eq("clear_count", clr_cnt, COLS);
        check_eq("sb_left", exp_q.size(), 0);
        if (start_on_done) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            check_eq("start_on_done_busy", busy, 0);
            repeat (2) @(negedge clock);
            check_eq("start_on_done_idle", px_valid, 0);
        end else begin
            @(negedge clock);
            check_eq("busy_after_done", busy, 0);
        end
    endtask

    task automatic wait_bytes(input int n);
        int budget;
        budget = 0;
        while (byte_cnt < n && budget < 6000) begin
            @(negedge clock);
            budget++;
        end
        check_eq("reach_byte", byte_cnt >= n, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_valid"}, px_valid, 0);
        check_eq({tag, "_data"}, px_data, 0);
        check_eq({tag, "_last"}, px_last, 0);
        check_eq({tag, "_fe"}, font_enable, 0);
        check_eq({tag, "_addr"}, font_address, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        string digits;
        int    nsp;
        digits = "0123456789ABCD";
        for (int i = 0; i < 16; i++) text_m[i] = 8'h20;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        #1 reset = 1'b0;

        // full line of distinct glyphs, ready tied high
        for (int i = 0; i < COLS; i++) write_char(4'(i), digits[i]);
        start_line();
        finish_line(1'b1, 1'b0);
        check_eq("row_bytes", byte_cnt, LCD_ROW_BYTES);

        // repeated code, plus start coincident with done
        write_char(4'd0, "A");
        write_char(4'd1, "A");
        start_line();
        finish_line(1'b1, 1'b1);

        // random backpressure
        rdy_rand = 1'b1;
        start_line();
        finish_line(1'b0, 1'b0);
        rdy_rand = 1'b0;

        // zero-width spaces
        blank_zero = 1'b1;
        write_char(4'd2, 8'h20);
        write_char(4'd5, 8'h20);
        write_char(4'd6, 8'h20);
        write_char(4'd13, 8'h20);
        nsp = 0;
        for (int i = 0; i < COLS; i++) if (text_m[i] == 8'h20) nsp++;
        start_line();
        finish_line(1'b1, 1'b0);
        check_eq("blank_total", byte_cnt, LCD_ROW_BYTES - 5 * nsp);
        blank_zero = 1'b0;

        // start while busy, write to an out-of-range entry and an already-passed entry
        start_line();
        wait_bytes(20);
        @(negedge clock);
        start      = 1'b1;
        text_we    = 1'b1;
        text_waddr = 4'd15;
        text_wdata = 8'h55;
        @(negedge clock);
        text_waddr = 4'd0;
        text_wdata = 8'h5A;
        @(negedge clock);
        text_we   = 1'b0;
        start     = 1'b0;
        text_m[0] = 8'h5A;
        finish_line(1'b0, 1'b0);
        start_line();
        finish_line(1'b1, 1'b0);

        // reset in the middle of a line
        start_line();
        wait_bytes(40);
        @(negedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        exp_q.delete();
        for (int i = 0; i < 16; i++) text_m[i] = 8'h20;
        #1 reset = 1'b0;
        start_line();
        finish_line(1'b1, 1'b0);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
